ahb_mem_slave_resp: RTL and testbench



---
 rtl/ahb_slv_pkg.sv | 29 ++
 rtl/ahb_slv_lane_dec.sv | 31 +++
 rtl/ahb_mem_slave_resp.sv | 139 +++++++++++++
 tb/tb_ahb_mem_slave_resp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slv_pkg.sv
// Shared AHB-Lite slave definitions: transfer/response/size codes and responder FSM states.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int unsigned WS_CNT_W = 4;

endpackage

// File: rtl/ahb_slv_lane_dec.sv
// Byte-lane decoder: transfer size and low address bits to a 4-bit write strobe and alignment flag.
module ahb_slv_lane_dec
  import ahb_slv_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] offset,
  output logic [3:0] strb_c,
  output logic       aligned_c
);

  always_comb begin
    strb_c    = 4'b0000;
    aligned_c = 1'b0;
    case (size)
      HSIZE_BYTE: begin
        strb_c    = 4'b0001 << offset;
        aligned_c = 1'b1;
      end
      HSIZE_HALF: begin
        strb_c    = offset[1] ? 4'b1100 : 4'b0011;
        aligned_c = ~offset[0];
      end
      HSIZE_WORD: begin
        strb_c    = 4'b1111;
        aligned_c = (offset == 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_mem_slave_resp.sv
// AHB-Lite memory slave responder: word memory with byte-lane writes, configurable wait states
// and the two-cycle ERROR response for illegal accesses.
module ahb_mem_slave_resp
  import ahb_slv_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [31:0] HWDATAS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] HRDATAS
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]         mem [MEM_WORDS];
  state_e              state;
  logic [WS_CNT_W-1:0] wait_cnt;
  logic                hready_q;
  logic                hresp_q;
  logic                dp_valid;
  logic                dp_write;
  logic [AW-1:0]       dp_idx;
  logic [3:0]          dp_strb;

  logic                accept_c;
  logic                illegal_c;
  logic                aligned_c;
  logic                size_bad_c;
  logic                range_bad_c;
  logic                commit_c;
  logic [3:0]          strb_c;

  ahb_slv_lane_dec u_lane_dec (
    .size      (HSIZES),
    .offset    (HADDRS[1:0]),
    .strb_c    (strb_c),
    .aligned_c (aligned_c)
  );

  assign accept_c    = HSELS & HREADYS &
                       ((HTRANSS == HTRANS_NONSEQ) | (HTRANSS == HTRANS_SEQ));
  assign size_bad_c  = (HSIZES > HSIZE_WORD);
  assign range_bad_c = (HADDRS[31:2] >= 30'(MEM_WORDS));
  assign illegal_c   = size_bad_c | ~aligned_c | range_bad_c;

  // A write lands only on the edge that ends its final data-phase cycle; a coinciding reset drops it.
  assign commit_c    = HRESETn & dp_valid & dp_write & hready_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_strb  <= '0;
    end else begin
      case (state)
        // ERR2 is the completing cycle of an error, so a new address phase is taken as from IDLE.
        ST_IDLE, ST_ERR2: begin
          if (accept_c) begin
            dp_idx   <= HADDRS[AW+1:2];
            dp_strb  <= strb_c;
            dp_write <= HWRITES;
            if (illegal_c) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
              dp_valid <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WS_CNT_W'(WAIT_STATES - 1);
              hready_q <= 1'b0;
              hresp_q  <= HRESP_OKAY;
              dp_valid <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              hready_q <= 1'b1;
              hresp_q  <= HRESP_OKAY;
              dp_valid <= 1'b1;
            end
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            dp_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WS_CNT_W'(1);
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state    <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          dp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Memory array is deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (commit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_strb[i]) begin
          mem[dp_idx][8*i +: 8] <= HWDATAS[8*i +: 8];
        end
      end
    end
  end

  assign HREADYOUTS = hready_q;
  assign HRESPS     = hresp_q;
  assign HRDATAS    = (dp_valid & ~dp_write) ? mem[dp_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave_resp.sv
// Scoreboard bench: three responders (0, 2 and 3 wait states) share one bus; the active one is checked.
module tb_ahb_mem_slave_resp;
  import ahb_slv_pkg::*;

  localparam int unsigned NDUT = 3;
  localparam int unsigned MEMW = 256;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int unsigned waits;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] hsel;
  logic [NDUT-1:0] hrdy;
  logic [NDUT-1:0] hresp;
  logic [31:0]     hrdata [NDUT];
  logic [31:0]     haddr;
  logic [31:0]     hwdata;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_mem_slave_resp #(
      .MEM_WORDS   (MEMW),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .HCLK       (clk),
      .HRESETn    (rst_n),
      .HSELS      (hsel[g]),
      .HADDRS     (haddr),
      .HTRANSS    (htrans),
      .HWRITES    (hwrite),
      .HSIZES     (hsize),
      .HWDATAS    (hwdata),
      .HREADYS    (hrdy[g]),
      .HREADYOUTS (hrdy[g]),
      .HRESPS     (hresp[g]),
      .HRDATAS    (hrdata[g])
    );
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          act = 0;
  int          last_done = 0;
  int          t0 = 0;
  exp_t        sbq [$];
  exp_t        dp;
  logic        dp_v = 1'b0;
  int unsigned dp_k = 0;
  logic        m_rdy;
  logic [31:0] m_dat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned ws_of(input int a);
    return (a == 0) ? 0 : ((a == 1) ? 2 : 3);
  endfunction

  task automatic check3(input string nm, input logic a_rdy, input logic a_rsp, input logic [31:0] a_dat,
                        input logic e_rdy, input logic e_rsp, input logic [31:0] e_dat);
    checks++;
    if (a_rdy !== e_rdy || a_rsp !== e_rsp || a_dat !== e_dat) begin
      errors++;
      $display("FAIL %s @cyc %0d: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
               nm, cyc, a_rdy, a_rsp, a_dat, e_rdy, e_rsp, e_dat);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // Monitor: checks every cycle of the active slave against the popped expectation or the idle response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp_v = 1'b0;
      end else begin
        if (dp_v) begin
          m_rdy = dp.err ? (dp_k == 1) : (dp_k == dp.waits);
          m_dat = (!dp.err && dp.rd) ? dp.data : 32'h0;
          check3("dphase", hrdy[act], hresp[act], hrdata[act], m_rdy, dp.err, m_dat);
          if (m_rdy) begin
            dp_v      = 1'b0;
            last_done = cyc + 1;
          end else begin
            dp_k++;
          end
        end else begin
          check3("idle", hrdy[act], hresp[act], hrdata[act], 1'b1, 1'b0, 32'h0);
        end
        if (hsel[act] && htrans[1] && hrdy[act]) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL accept: got accept at cyc %0d, want no transfer pending", cyc);
          end else begin
            dp   = sbq.pop_front();
            dp_k = 0;
            dp_v = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one address phase, hold it until accepted, then drive its write data.
  task automatic xfer(input logic wr, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input logic err, input logic [31:0] rd_exp);
    exp_t e;
    int   n;
    e.err   = err;
    e.rd    = ~wr;
    e.data  = rd_exp;
    e.waits = ws_of(act);
    sbq.push_back(e);
    hsel      = '0;
    hsel[act] = 1'b1;
    htrans    = tr;
    haddr     = a;
    hwrite    = wr;
    hsize     = sz;
    n         = 0;
    @(negedge clk);
    while (!hrdy[act] && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!hrdy[act]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got hready=0 for %0d cycles, want 1", n);
    end
    step();
    hwdata = wd;
  endtask

  task automatic drain();
    int n;
    n      = 0;
    htrans = HTRANS_IDLE;
    hsel   = '0;
    hwrite = 1'b0;
    while ((dp_v || sbq.size() != 0) && n < 60) begin
      step();
      n++;
    end
    if (dp_v || sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sbq.size());
      sbq.delete();
    end
    step();
  endtask

  task automatic noacc(input logic sel, input logic [1:0] tr);
    hsel      = '0;
    hsel[act] = sel;
    htrans    = tr;
    haddr     = 32'h20;
    hwrite    = 1'b1;
    hsize     = HSIZE_WORD;
    step();
    hwdata = 32'h0BADBAD0;
    htrans = HTRANS_IDLE;
    hsel   = '0;
    step();
    step();
  endtask

  initial begin
    rst_n  = 1'b0;
    hsel   = '0;
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
    hwdata = '0;
    repeat (3) step();
    for (int i = 0; i < NDUT; i++) check3("reset", hrdy[i], hresp[i], hrdata[i], 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();

    // Zero wait states: back-to-back write/read, lane writes, illegal accesses, boundary word.
    act = 0;
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hDEADBEEF);
    drain();
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h11223344, 1'b0, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h13, HSIZE_BYTE, 32'hAA000000, 1'b0, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'hAA223344);
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h11223344, 1'b0, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h12, HSIZE_HALF, 32'h55660000, 1'b0, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'h55663344);
    xfer(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_HALF, 32'h0000CAFE, 1'b0, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 32'h5566CAFE);
    drain();
    xfer(1'b1, HTRANS_NONSEQ, 32'h00, HSIZE_WORD, 32'h01020304, 1'b0, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, MEMW * 4, HSIZE_WORD, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, MEMW * 4, HSIZE_WORD, 32'h0, 1'b1, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h00, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(1'b1, HTRANS_NONSEQ, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, 32'h00, HSIZE_WORD, 32'h0, 1'b0, 32'h01020304);
    xfer(1'b1, HTRANS_NONSEQ, MEMW * 4 - 4, HSIZE_WORD, 32'h5A5A5A5A, 1'b0, 32'h0);
    xfer(1'b0, HTRANS_NONSEQ, MEMW * 4 - 4, HSIZE_WORD, 32'h0, 1'b0, 32'h5A5A5A5A);
    drain();

    // Two wait states: single transfers, 4-beat INCR read burst timing, ignored non-transfers.
    act = 1;
    xfer(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'hCAFEF00D, 1'b0, 32'h0);
    drain();
    xfer(1'b0, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D);
    drain();
    xfer(1'b1, HTRANS_NONSEQ, 32'h24, HSIZE_WORD, 32'h24242424, 1'b0, 32'h0);
    xfer(1'b1, HTRANS_SEQ,    32'h28, HSIZE_WORD, 32'h28282828, 1'b0, 32'h0);
    xfer(1'b1, HTRANS_SEQ,    32'h2C, HSIZE_WORD, 32'h2C2C2C2C, 1'b0, 32'h0);
    drain();
    xfer(1'b0, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D);
    t0 = cyc;
    xfer(1'b0, HTRANS_SEQ, 32'h24, HSIZE_WORD, 32'h0, 1'b0, 32'h24242424);
    xfer(1'b0, HTRANS_SEQ, 32'h28, HSIZE_WORD, 32'h0, 1'b0, 32'h28282828);
    xfer(1'b0, HTRANS_SEQ, 32'h2C, HSIZE_WORD, 32'h0, 1'b0, 32'h2C2C2C2C);
    drain();
    check_int("burst_cycles", last_done - t0, 12);
    noacc(1'b1, HTRANS_IDLE);
    noacc(1'b1, HTRANS_BUSY);
    noacc(1'b0, HTRANS_NONSEQ);
    xfer(1'b0, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 32'hCAFEF00D);
    drain();

    // Three wait states: reset during the wait of a write leaves the old word in place.
    act = 2;
    xfer(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 32'h12345678, 1'b0, 32'h0);
    drain();
    xfer(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 32'h87654321, 1'b0, 32'h0);
    htrans = HTRANS_IDLE;
    hsel   = '0;
    step();
    rst_n = 1'b0;
    step();
    check3("reset_mid_wait", hrdy[act], hresp[act], hrdata[act], 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    step();
    xfer(1'b0, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 32'h0, 1'b0, 32'h12345678);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end

endmodule
